// File: rtl/ariane_axi_pkg.sv
// ariane_axi: AXI channel payloads, bundled req/resp and the slice mode encoding
package ariane_axi;
  typedef enum logic [1:0] {BYPASS = 2'd0, HALF = 2'd1, FULL = 2'd2} slice_mode_t;
  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } aw_chan_t;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;
  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_chan_t;
  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;
  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;
  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

// File: rtl/axi_slice_reg.sv
// axi_slice_reg: one valid/ready register slice, bypass, half (1 entry) or full (2 entry)
module axi_slice_reg
  import ariane_axi::*;
#(
  parameter type         T    = logic,
  parameter int unsigned Mode = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data,
  output logic busy
);
  localparam slice_mode_t M = slice_mode_t'(Mode[1:0]);
  if (Mode > 2) begin : g_bad
    $fatal(1, "axi_slice_reg: Mode %0d is not 0, 1 or 2", Mode);
  end
  if (M == BYPASS) begin : g_bypass
    logic unused;
    assign unused    = clk_i ^ rst_ni;
    assign in_ready  = out_ready;
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign busy      = 1'b0;
  end else if (M == HALF) begin : g_half
    // live holds in-ready low during reset and releases it on the first edge after
    logic live, full;
    T     data;
    assign in_ready  = live & ~full;
    assign out_valid = full;
    assign out_data  = data;
    assign busy      = full;
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
        live <= 1'b0;
        full <= 1'b0;
      end else begin
        live <= 1'b1;
        full <= full ? ~out_ready : in_valid & live;
      end
    always_ff @(posedge clk_i)
      if (in_valid && in_ready) data <= in_data;
  end else begin : g_full
    // main drives the output; skid catches the beat accepted while main stalls
    logic live, mv, sv, push, pop;
    T     md, sd;
    assign in_ready  = live & ~sv;
    assign out_valid = mv;
    assign out_data  = md;
    assign busy      = mv | sv;
    assign push      = in_valid & in_ready;
    assign pop       = mv & out_ready;
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
        live <= 1'b0;
        mv   <= 1'b0;
        sv   <= 1'b0;
      end else begin
        live <= 1'b1;
        mv   <= sv | push | (mv & ~out_ready);
        sv   <= sv ? ~pop : push & mv & ~out_ready;
      end
    always_ff @(posedge clk_i) begin
      if (push && mv && !pop) sd <= in_data;
      if (pop && sv) md <= sd;
      else if (push && (!mv || pop)) md <= in_data;
    end
  end
endmodule

// File: rtl/axi_chan_slice.sv
// axi_chan_slice: independent register slices on the five AXI channels
module axi_chan_slice #(
  parameter int unsigned AwMode = 2,
  parameter int unsigned WMode  = 2,
  parameter int unsigned BMode  = 2,
  parameter int unsigned ArMode = 2,
  parameter int unsigned RMode  = 2,
  parameter type aw_chan_t = ariane_axi::aw_chan_t,
  parameter type w_chan_t  = ariane_axi::w_chan_t,
  parameter type b_chan_t  = ariane_axi::b_chan_t,
  parameter type ar_chan_t = ariane_axi::ar_chan_t,
  parameter type r_chan_t  = ariane_axi::r_chan_t,
  parameter type req_t     = ariane_axi::req_t,
  parameter type resp_t    = ariane_axi::resp_t
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  req_t  slv_req_i,
  output resp_t slv_resp_o,
  output req_t  mst_req_o,
  input  resp_t mst_resp_i,
  output logic  busy_o
);
  logic [4:0] busy;
  axi_slice_reg #(.T(aw_chan_t), .Mode(AwMode)) i_aw (
    .clk_i, .rst_ni,
    .in_valid(slv_req_i.aw_valid), .in_ready(slv_resp_o.aw_ready), .in_data(slv_req_i.aw),
    .out_valid(mst_req_o.aw_valid), .out_ready(mst_resp_i.aw_ready), .out_data(mst_req_o.aw),
    .busy(busy[0])
  );
  axi_slice_reg #(.T(w_chan_t), .Mode(WMode)) i_w (
    .clk_i, .rst_ni,
    .in_valid(slv_req_i.w_valid), .in_ready(slv_resp_o.w_ready), .in_data(slv_req_i.w),
    .out_valid(mst_req_o.w_valid), .out_ready(mst_resp_i.w_ready), .out_data(mst_req_o.w),
    .busy(busy[1])
  );
  axi_slice_reg #(.T(b_chan_t), .Mode(BMode)) i_b (
    .clk_i, .rst_ni,
    .in_valid(mst_resp_i.b_valid), .in_ready(mst_req_o.b_ready), .in_data(mst_resp_i.b),
    .out_valid(slv_resp_o.b_valid), .out_ready(slv_req_i.b_ready), .out_data(slv_resp_o.b),
    .busy(busy[2])
  );
  axi_slice_reg #(.T(ar_chan_t), .Mode(ArMode)) i_ar (
    .clk_i, .rst_ni,
    .in_valid(slv_req_i.ar_valid), .in_ready(slv_resp_o.ar_ready), .in_data(slv_req_i.ar),
    .out_valid(mst_req_o.ar_valid), .out_ready(mst_resp_i.ar_ready), .out_data(mst_req_o.ar),
    .busy(busy[3])
  );
  axi_slice_reg #(.T(r_chan_t), .Mode(RMode)) i_r (
    .clk_i, .rst_ni,
    .in_valid(mst_resp_i.r_valid), .in_ready(mst_req_o.r_ready), .in_data(mst_resp_i.r),
    .out_valid(slv_resp_o.r_valid), .out_ready(slv_req_i.r_ready), .out_data(slv_resp_o.r),
    .busy(busy[4])
  );
  assign busy_o = |busy;
endmodule
